// File: rtl/readout_scheduler.sv
// Frame-level readout sequencer: walks the enabled channels of a latched mask,
// pulses a parallel load per channel, shifts WORD_W bits under tx_ready, then clears.
module readout_scheduler #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4,
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ovf,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              tx_ready,
  input  logic              overrun_clr,
  output logic [SEL_W-1:0]  selection,
  output logic              SL,
  output logic              shift_en,
  output logic [3:0]        bit_idx,
  output logic              rst,
  output logic              frame_busy,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_NEXT  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

  state_t            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [SEL_W-1:0]  r_sel;
  logic [3:0]        r_bit;
  logic              r_ovr;
  logic [7:0]        r_cnt;

  logic              w_first_hit;
  logic [SEL_W-1:0]  w_first_idx;
  logic              w_next_hit;
  logic [SEL_W-1:0]  w_next_idx;

  // Downward scans so the last assignment wins, leaving the lowest qualifying index.
  always_comb begin
    w_first_hit = 1'b0;
    w_first_idx = '0;
    w_next_hit  = 1'b0;
    w_next_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_first_hit = 1'b1;
        w_first_idx = SEL_W'(i);
      end
      if (r_mask[i] && (SEL_W'(i) > r_sel)) begin
        w_next_hit = 1'b1;
        w_next_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_sel   <= '0;
      r_bit   <= '0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // A tick outside IDLE only flags overrun; the set has priority over the clear.
      if (ovf && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end else if (overrun_clr) begin
        r_ovr <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (ovf) begin
            r_mask <= ch_mask;
            if (w_first_hit) begin
              r_sel   <= w_first_idx;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_LOAD: begin
          r_bit   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tx_ready) begin
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_state <= S_NEXT;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        S_NEXT: begin
          if (w_next_hit) begin
            r_sel   <= w_next_idx;
            r_state <= S_LOAD;
          end else begin
            r_sel   <= '0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt   <= r_cnt + 8'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign selection  = r_sel;
  assign bit_idx    = r_bit;
  assign overrun    = r_ovr;
  assign frame_cnt  = r_cnt;
  assign SL         = (r_state == S_LOAD);
  assign rst        = (r_state == S_CLEAR);
  assign frame_busy = (r_state != S_IDLE);
  assign shift_en   = (r_state == S_SHIFT) && tx_ready;

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler: table of whole-frame vectors plus
// hand-written reset-abort and reset-state sequences.
module tb_readout_scheduler;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int WORD_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              ovf;
  logic [NUM_CH-1:0] ch_mask;
  logic              tx_ready;
  logic              overrun_clr;
  logic [SEL_W-1:0]  selection;
  logic              SL;
  logic              shift_en;
  logic [3:0]        bit_idx;
  logic              rst;
  logic              frame_busy;
  logic              overrun;
  logic [7:0]        frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  readout_scheduler #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .ovf(ovf), .ch_mask(ch_mask), .tx_ready(tx_ready),
    .overrun_clr(overrun_clr), .selection(selection), .SL(SL), .shift_en(shift_en),
    .bit_idx(bit_idx), .rst(rst), .frame_busy(frame_busy), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    bit          toggle;   // tx_ready high only on even cycles
    int          ovf2_at;  // extra in-frame ovf, -1 = none
    int          both_at;  // ovf + overrun_clr together
    int          clr_at;   // overrun_clr alone
    int          exp_sl;
    int          exp_shifts;
    int          exp_rst;  // cycle of rst relative to the ovf cycle
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int kth_bit(input logic [15:0] m, input int k);
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[i]) begin
        if (n == k) return i;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic run_frame(input vec_t v);
    int  sl_n = 0, sh_n = 0, rst_at = -1, busy_n = 0, word_sh = 0, cur_sel = 0;
    bit  done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      ovf         = (c == 0) || (c == v.ovf2_at) || (c == v.both_at);
      overrun_clr = (c == v.both_at) || (c == v.clr_at);
      tx_ready    = v.toggle ? (c % 2 == 0) : 1'b1;
      ch_mask     = (c == 0) ? v.mask : 16'($urandom_range(0, 65535));
      #1;
      if (c > 0) begin
        if (frame_busy) busy_n++;
        if (SL) begin
          if (sl_n > 0) chk("word_strobes", word_sh, WORD_W);
          cur_sel = kth_bit(v.mask, sl_n);
          chk("sl_selection", selection, cur_sel);
          if (!v.toggle) chk("sl_cycle", c, 1 + 14 * sl_n);
          sl_n++;
          word_sh = 0;
        end
        if (shift_en) begin
          chk("bit_idx", bit_idx, word_sh);
          chk("shift_sel", selection, cur_sel);
          word_sh++;
          sh_n++;
        end else if (v.toggle && frame_busy && word_sh > 0 && word_sh < WORD_W) begin
          chk("stall_bit_idx", bit_idx, word_sh);
          chk("stall_sel", selection, cur_sel);
        end
        if (rst) begin
          if (rst_at < 0) rst_at = c;
          chk("clear_sel", selection, 0);
        end
        if (c == v.ovf2_at + 1 || c == v.both_at + 1) chk("overrun_set", overrun, 1);
        if (c == v.clr_at + 1) chk("overrun_cleared", overrun, 0);
        if (!frame_busy) done = 1;
      end
    end
    if (!done) chk("frame_timeout", 0, 1);
    if (v.exp_sl > 0) chk("last_word_strobes", word_sh, WORD_W);
    chk("sl_count", sl_n, v.exp_sl);
    chk("shift_count", sh_n, v.exp_shifts);
    chk("rst_cycle", rst_at, v.exp_rst);
    chk("busy_cycles", busy_n, v.exp_rst);
    chk("overrun_end", overrun, v.exp_ovr);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("frame_cnt", frame_cnt, exp_cnt);
    @(negedge clk);
    ovf = 1'b0;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_selection"}, selection, 0);
    chk({tag, "_SL"}, SL, 0);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_bit_idx"}, bit_idx, 0);
    chk({tag, "_rst"}, rst, 0);
    chk({tag, "_busy"}, frame_busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 0, -1, -1, -1, 16, 192, 225, 0};
    vecs[1] = '{16'h8005, 0, -1, -1, -1,  3,  36,  43, 0};
    vecs[2] = '{16'h0000, 0, -1, -1, -1,  0,   0,   1, 0};
    vecs[3] = '{16'h0001, 1, -1, -1, -1,  1,  12,  26, 0};
    vecs[4] = '{16'h0030, 0, -1, -1, -1,  2,  24,  29, 0};
    vecs[5] = '{16'hFFFF, 0, 50, 60, 70, 16, 192, 225, 0};
    vecs[6] = '{16'h0000, 0,  1, -1, -1,  0,   0,   1, 1};

    reset = 1'b1; ovf = 1'b0; ch_mask = '0; tx_ready = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("por");

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset during SHIFT of channel 5 (mask 0x0030: ch5 shifts in cycles 16..27).
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      ovf      = (c == 0) || (c == 10);
      ch_mask  = 16'h0030;
      tx_ready = 1'b1;
      reset    = (c == 20);
      #1;
      if (c == 20) begin
        chk("abort_pre_sel", selection, 5);
        chk("abort_pre_shift", shift_en, 1);
        chk("abort_pre_ovr", overrun, 1);
      end
      if (c == 21) chk_reset_state("abort");
    end
    ovf = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rst", rst, 0);
    end
    exp_cnt = 0;
    run_frame(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
